// File: rtl/zx_video_pkg.sv
// Shared constants and FSM encoding for the ULA VRAM fetch path.
package zx_video_pkg;

  localparam int unsigned SCREEN_COLS  = 32;
  localparam int unsigned SCREEN_LINES = 192;
  localparam int unsigned X_W          = $clog2(SCREEN_COLS);
  localparam int unsigned Y_W          = $clog2(SCREEN_LINES);
  localparam int unsigned ADDR_W       = 16;
  localparam int unsigned DATA_W       = 8;
  localparam int unsigned CNT_W        = 4;

  localparam logic [2:0] VRAM_PREFIX = 3'b010;
  localparam logic [5:0] ATTR_PREFIX = 6'b010110;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BMP,
    ST_GAP,
    ST_ATT,
    ST_DONE
  } fetch_state_e;

endpackage

// File: rtl/zx_vram_addr.sv
// Maps a character cell (column, pixel line) onto its bitmap and attribute VRAM addresses.
module zx_vram_addr
  import zx_video_pkg::*;
(
  input  logic [X_W-1:0]    x_char,
  input  logic [Y_W-1:0]    y_line,
  output logic [ADDR_W-1:0] bitmap_addr_c,
  output logic [ADDR_W-1:0] attr_addr_c
);

  // Bitmap rows interleave third / char-row / pixel-row, hence the swapped y fields.
  assign bitmap_addr_c = {VRAM_PREFIX, y_line[7:6], y_line[2:0], y_line[5:3], x_char};
  assign attr_addr_c   = {ATTR_PREFIX, y_line[7:3], x_char};

endmodule

// File: rtl/zx_video_fetch.sv
// Bank-1 read sequencer: fetches the bitmap then attribute byte of one character cell.
module zx_video_fetch
  import zx_video_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_start,
  input  logic [X_W-1:0]    x_char,
  input  logic [Y_W-1:0]    y_line,
  output logic              busy,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] pix_byte,
  output logic [DATA_W-1:0] attr_byte,
  output logic              overrun,
  output logic [ADDR_W-1:0] a1,
  output logic              cs1_n,
  output logic              oe1_n,
  output logic              we1_n,
  output logic [DATA_W-1:0] din1,
  input  logic [DATA_W-1:0] dout1
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

  fetch_state_e      state;
  logic [CNT_W-1:0]  cnt;
  logic [X_W-1:0]    x_q;
  logic [Y_W-1:0]    y_q;
  logic              armed;
  logic              strobe_n;

  logic              ready_c;
  logic              accept_c;
  logic [X_W-1:0]    addr_x_c;
  logic [Y_W-1:0]    addr_y_c;
  logic [ADDR_W-1:0] bitmap_addr_c;
  logic [ADDR_W-1:0] attr_addr_c;

  // A start coinciding with reset release is dropped: armed is still low on that edge.
  assign ready_c  = (state == ST_IDLE) || (state == ST_DONE);
  assign accept_c = armed && fetch_start && ready_c;

  // Live inputs feed the bitmap address at accept; the latched cell feeds the attribute later.
  assign addr_x_c = ready_c ? x_char : x_q;
  assign addr_y_c = ready_c ? y_line : y_q;

  zx_vram_addr u_addr (
    .x_char        (addr_x_c),
    .y_line        (addr_y_c),
    .bitmap_addr_c (bitmap_addr_c),
    .attr_addr_c   (attr_addr_c)
  );

  assign cs1_n = strobe_n;
  assign oe1_n = strobe_n;
  assign we1_n = 1'b1;
  assign din1  = '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      armed       <= 1'b0;
      strobe_n    <= 1'b1;
      busy        <= 1'b0;
      fetch_valid <= 1'b0;
      overrun     <= 1'b0;
      pix_byte    <= '0;
      attr_byte   <= '0;
      a1          <= '0;
    end else begin
      armed       <= 1'b1;
      fetch_valid <= 1'b0;
      overrun     <= fetch_start && !ready_c;

      case (state)
        ST_IDLE: begin
          strobe_n <= 1'b1;
        end
        ST_BMP: begin
          strobe_n <= 1'b0;
          if (cnt == '0) state <= ST_GAP;
          else           cnt   <= cnt - CNT_W'(1);
        end
        // Strobes rise here: the last low cycle just ended, so its data is captured now.
        ST_GAP: begin
          strobe_n <= 1'b1;
          pix_byte <= dout1;
          a1       <= attr_addr_c;
          cnt      <= CNT_LOAD;
          state    <= ST_ATT;
        end
        ST_ATT: begin
          strobe_n <= 1'b0;
          if (cnt == '0) state <= ST_DONE;
          else           cnt   <= cnt - CNT_W'(1);
        end
        ST_DONE: begin
          strobe_n    <= 1'b1;
          attr_byte   <= dout1;
          fetch_valid <= 1'b1;
          busy        <= 1'b0;
          state       <= ST_IDLE;
        end
        default: begin
          strobe_n <= 1'b1;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase

      // Accept from IDLE or DONE; DONE acceptance gives back-to-back fetches.
      if (accept_c) begin
        x_q   <= x_char;
        y_q   <= y_line;
        a1    <= bitmap_addr_c;
        cnt   <= CNT_LOAD;
        busy  <= 1'b1;
        state <= ST_BMP;
      end
    end
  end

endmodule

// File: tb/tb_zx_video_fetch.sv
// Bench for zx_video_fetch: SRAM-controller model, directed corners and random cell fetches.
module tb_zx_video_fetch;

  localparam int A = 6;
  localparam int V = 2 * A + 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_start;
  logic [4:0]  x_char;
  logic [7:0]  y_line;
  logic        busy, fetch_valid, overrun, cs1_n, oe1_n, we1_n;
  logic [7:0]  pix_byte, attr_byte, din1, dout1;
  logic [15:0] a1;

  int total = 0;
  int bad   = 0;
  int lowcnt = 0;
  logic [7:0] prev_pix = 8'h00;
  logic [7:0] prev_att = 8'h00;

  always #5 clk = ~clk;

  zx_video_fetch #(.ACCESS_CYCLES(A)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start), .x_char(x_char), .y_line(y_line),
    .busy(busy), .fetch_valid(fetch_valid), .pix_byte(pix_byte), .attr_byte(attr_byte),
    .overrun(overrun), .a1(a1), .cs1_n(cs1_n), .oe1_n(oe1_n), .we1_n(we1_n),
    .din1(din1), .dout1(dout1)
  );

  // Screen memory layout written out arithmetically
  function automatic logic [15:0] bmp_m(input int x, input int y);
    return 16'(32'h4000 + (y / 64) * 2048 + (y % 8) * 256 + ((y / 8) % 8) * 32 + x);
  endfunction

  function automatic logic [15:0] att_m(input int x, input int y);
    return 16'(32'h5800 + (y / 8) * 32 + x);
  endfunction

  function automatic logic [7:0] data_of(input logic [15:0] a);
    if (a == 16'h4000) return 8'hAA;
    if (a == 16'h5800) return 8'h55;
    return 8'((32'(a) * 13) ^ (32'(a) >> 7));
  endfunction

  // Controller model: data is only driven once a strobe has been low for 3+ cycles
  always @(posedge clk) lowcnt <= cs1_n ? 0 : lowcnt + 1;
  assign dout1 = (!cs1_n && lowcnt >= 3) ? data_of(a1) : 8'hEE;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Follows one fetch whose start was sampled at edge 0; k counts edges, checks at negedge.
  task automatic fetch(input int x, input int y, input int k0, input bit ovr,
                       input bit chain, input int nx, input int ny);
    logic [15:0] eb, ea;
    logic [7:0]  ep, eat;
    bit          low;
    eb  = bmp_m(x, y);
    ea  = att_m(x, y);
    ep  = data_of(eb);
    eat = data_of(ea);
    for (int k = k0; k <= V; k++) begin
      @(negedge clk);
      if (k == V) begin
        chk("valid_pulse", 16'(fetch_valid), 16'd1);
        chk("pix_byte", 16'(pix_byte), 16'(ep));
        chk("attr_byte", 16'(attr_byte), 16'(eat));
        chk("cs_done", 16'(cs1_n), 16'd1);
        chk("busy_done", 16'(busy), 16'(chain));
        chk("overrun_done", 16'(overrun), 16'd0);
        chk("a1_done", a1, chain ? bmp_m(nx, ny) : ea);
        prev_pix = ep;
        prev_att = eat;
      end else begin
        low = (k >= 1 && k <= A) || (k >= A + 2 && k <= 2 * A + 1);
        chk($sformatf("cs1_n_k%0d", k), 16'(cs1_n), 16'(!low));
        chk($sformatf("oe1_n_k%0d", k), 16'(oe1_n), 16'(!low));
        chk($sformatf("a1_k%0d", k), a1, (k <= A) ? eb : ea);
        chk($sformatf("busy_k%0d", k), 16'(busy), 16'd1);
        chk($sformatf("valid_k%0d", k), 16'(fetch_valid), 16'd0);
        chk($sformatf("overrun_k%0d", k), 16'(overrun), 16'(ovr && k == 4));
        chk($sformatf("pix_hold_k%0d", k), 16'(pix_byte), 16'((k >= A + 1) ? ep : prev_pix));
        chk($sformatf("attr_hold_k%0d", k), 16'(attr_byte), 16'(prev_att));
        if (k == 0) begin
          chk("we1_n", 16'(we1_n), 16'd1);
          chk("din1", 16'(din1), 16'd0);
        end
      end
      fetch_start = 1'b0;
      x_char = 5'($urandom_range(31));
      y_line = 8'($urandom_range(255));
      if (ovr && k == 3) fetch_start = 1'b1;
      if (chain && k == 2 * A + 1) begin
        fetch_start = 1'b1;
        x_char = 5'(nx);
        y_line = 8'(ny);
      end
    end
  endtask

  initial begin
    int cx, cy, nx, ny, k0;
    bit ch;
    rst_n = 1'b0;
    fetch_start = 1'b0;
    x_char = '0;
    y_line = '0;
    repeat (3) @(negedge clk);
    chk("rst_cs1_n", 16'(cs1_n), 16'd1);
    chk("rst_oe1_n", 16'(oe1_n), 16'd1);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_valid", 16'(fetch_valid), 16'd0);
    chk("rst_overrun", 16'(overrun), 16'd0);
    chk("rst_pix", 16'(pix_byte), 16'd0);
    chk("rst_attr", 16'(attr_byte), 16'd0);
    chk("rst_a1", a1, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    // Low corner: 4000/5800 with AA/55
    fetch_start = 1'b1; x_char = 5'd0; y_line = 8'd0;
    fetch(0, 0, 0, 1'b0, 1'b0, 0, 0);
    chk("corner_low_a1", a1, 16'h5800);

    // High corner chained straight into (5,9), which also takes an overrun
    fetch_start = 1'b1; x_char = 5'd31; y_line = 8'd191;
    fetch(31, 191, 0, 1'b0, 1'b1, 5, 9);
    fetch(5, 9, 1, 1'b1, 1'b0, 0, 0);
    chk("addr_5_9_att", a1, 16'h5825);

    // Reset during the third ATT strobe cycle
    fetch_start = 1'b1; x_char = 5'd3; y_line = 8'd77;
    for (int k = 0; k <= A + 4; k++) begin
      @(negedge clk);
      fetch_start = 1'b0;
    end
    chk("pre_rst_cs_low", 16'(cs1_n), 16'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_cs1_n", 16'(cs1_n), 16'd1);
    chk("midrst_oe1_n", 16'(oe1_n), 16'd1);
    chk("midrst_busy", 16'(busy), 16'd0);
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_valid", 16'(fetch_valid), 16'd0);
    end
    // Start coincident with reset release must be ignored
    rst_n = 1'b1; fetch_start = 1'b1; x_char = 5'd1; y_line = 8'd1;
    @(negedge clk);
    fetch_start = 1'b0;
    chk("rel_start_busy", 16'(busy), 16'd0);
    chk("rel_start_cs", 16'(cs1_n), 16'd1);
    @(negedge clk);
    chk("rel_start_cs2", 16'(cs1_n), 16'd1);
    chk("rel_pix_cleared", 16'(pix_byte), 16'd0);
    prev_pix = 8'h00;
    prev_att = 8'h00;

    // Random cells, randomly chained back-to-back
    cx = $urandom_range(31);
    cy = $urandom_range(191);
    k0 = 0;
    fetch_start = 1'b1; x_char = 5'(cx); y_line = 8'(cy);
    for (int i = 0; i < 10; i++) begin
      nx = $urandom_range(31);
      ny = (i == 4) ? $urandom_range(255, 192) : $urandom_range(191);
      ch = (i < 9) ? 1'($urandom_range(1)) : 1'b0;
      fetch(cx, cy, k0, 1'($urandom_range(1)), ch, nx, ny);
      cx = nx;
      cy = ny;
      if (ch) begin
        k0 = 1;
      end else begin
        k0 = 0;
        if (i < 9) begin
          fetch_start = 1'b1; x_char = 5'(cx); y_line = 8'(cy);
        end
      end
    end
    @(negedge clk);
    chk("final_idle_busy", 16'(busy), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
